// File: rtl/fsm_matrix_scan_param.sv
// fsm_matrix_scan_param: per-frame DAC bias programming then row-major ROWSxCOLS pixel scan with ADC handoff.
// Define FSM_MATRIX_TIMEOUT_EN to add a TO_CYC wait-state timeout driving the sticky err_o flag.
module fsm_matrix_scan_param #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int COL_W      = (COLS > 1) ? $clog2(COLS) : 1,
  parameter int DAC_WRITES = 2,
  parameter int DACCH_W    = (DAC_WRITES > 1) ? $clog2(DAC_WRITES) : 1,
  parameter int SETTLE_CYC = 16,
  parameter int TO_CYC     = 4096
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               cont_i,
  input  logic               abort_i,
  input  logic               eodac_i,
  input  logic               eoadc_i,
  input  logic               pix_ready_i,
  output logic               stdac_o,
  output logic [DACCH_W-1:0] dacch_o,
  output logic               stadc_o,
  output logic [ROW_W-1:0]   row_o,
  output logic [COL_W-1:0]   col_o,
  output logic               pix_valid_o,
  output logic               frame_done_o,
  output logic               busy_o,
  output logic               eos_o,
  output logic               err_o
);
  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  typedef enum logic [3:0] {IDLE, DAC_ST, DAC_WT, DAC_SET, PIX_SEL, ADC_ST, ADC_WT, PIX_OUT, NEXT} state_t;
  state_t state, nxt;
  logic [SET_W-1:0] set_cnt;
  logic set_done, last_dac, last_row, last_col, to_exp, clr, dac_inc;
  logic stdac_d, stadc_d, pix_valid_d, frame_done_d, busy_d, eos_d;
  assign set_done = set_cnt == SET_W'(SETTLE_CYC - 1);
  assign last_dac = dacch_o == DACCH_W'(DAC_WRITES - 1);
  assign last_row = row_o == ROW_W'(ROWS - 1);
  assign last_col = col_o == COL_W'(COLS - 1);
`ifdef FSM_MATRIX_TIMEOUT_EN
  localparam int TO_W = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  logic [TO_W-1:0] to_cnt;
  logic to_fire;
  assign to_exp = to_cnt == TO_W'(TO_CYC - 1);
  assign to_fire = to_exp && ((state == DAC_WT && !eodac_i) || (state == ADC_WT && !eoadc_i));
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      to_cnt <= '0;
      err_o  <= 1'b0;
    end else begin
      to_cnt <= ((state == DAC_WT || state == ADC_WT) && nxt == state) ? to_cnt + 1'b1 : '0;
      err_o  <= (state == IDLE && start_i) ? 1'b0 : (to_fire ? 1'b1 : err_o);
    end
  end
`else
  assign to_exp = 1'b0;
  assign err_o  = 1'b0;
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start_i ? DAC_ST : IDLE;
      DAC_ST:  nxt = DAC_WT;
      DAC_WT:  nxt = eodac_i ? DAC_SET : (to_exp ? IDLE : DAC_WT);
      DAC_SET: nxt = !set_done ? DAC_SET : (last_dac ? PIX_SEL : DAC_ST);
      PIX_SEL: nxt = set_done ? ADC_ST : PIX_SEL;
      ADC_ST:  nxt = ADC_WT;
      ADC_WT:  nxt = eoadc_i ? PIX_OUT : (to_exp ? IDLE : ADC_WT);
      PIX_OUT: nxt = pix_ready_i ? NEXT : PIX_OUT;
      NEXT:    nxt = !(last_row && last_col) ? PIX_SEL : (cont_i ? DAC_ST : IDLE);
      default: nxt = IDLE;
    endcase
    if (abort_i && state != IDLE) nxt = IDLE;
  end
  // Outputs are decoded from the next state and registered, so they line up with the state they describe.
  always_comb begin
    stdac_d      = nxt == DAC_ST;
    stadc_d      = nxt == ADC_ST;
    pix_valid_d  = nxt == PIX_OUT;
    frame_done_d = state == PIX_OUT && nxt == NEXT && last_row && last_col;
    busy_d       = nxt != IDLE;
    eos_d        = nxt == IDLE;
    clr          = nxt == IDLE || (nxt == DAC_ST && (state == IDLE || state == NEXT));
    dac_inc      = state == DAC_SET && nxt == DAC_ST;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      set_cnt      <= '0;
      dacch_o      <= '0;
      row_o        <= '0;
      col_o        <= '0;
      stdac_o      <= 1'b0;
      stadc_o      <= 1'b0;
      pix_valid_o  <= 1'b0;
      frame_done_o <= 1'b0;
      busy_o       <= 1'b0;
      eos_o        <= 1'b1;
    end else begin
      state        <= nxt;
      set_cnt      <= ((state == DAC_SET || state == PIX_SEL) && nxt == state) ? set_cnt + 1'b1 : '0;
      dacch_o      <= clr ? '0 : (dac_inc ? dacch_o + 1'b1 : dacch_o);
      col_o        <= clr ? '0 : (state == NEXT ? (last_col ? '0 : col_o + 1'b1) : col_o);
      row_o        <= clr ? '0 : (state == NEXT && last_col ? row_o + 1'b1 : row_o);
      stdac_o      <= stdac_d;
      stadc_o      <= stadc_d;
      pix_valid_o  <= pix_valid_d;
      frame_done_o <= frame_done_d;
      busy_o       <= busy_d;
      eos_o        <= eos_d;
    end
  end
endmodule

// File: tb/tb_fsm_matrix_scan_param.sv
// tb_fsm_matrix_scan_param: scoreboard bench for a 2x3 scan with 2 DAC writes and 4-cycle settle.
module tb_fsm_matrix_scan_param;
  logic clk = 1'b0, rst_i = 1'b1, start_i = 1'b0, cont_i = 1'b0, abort_i = 1'b0;
  logic eodac_i = 1'b0, eoadc_i = 1'b0, pix_ready_i = 1'b1;
  logic stdac_o, stadc_o, pix_valid_o, frame_done_o, busy_o, eos_o, err_o;
  logic [0:0] dacch_o, row_o;
  logic [1:0] col_o;
  int total = 0, bad = 0, adc_seen = 0;
  int q_dac[$], q_adc[$], q_fr[$];
  int dac_dly = 0, adc_dly = 0, prev_rc = 0;
  bit dac_en = 1, skip_en = 0, man_adc = 0, pv_prev = 0;

  always #5 clk = ~clk;

  fsm_matrix_scan_param #(.ROWS(2), .COLS(3), .DAC_WRITES(2), .SETTLE_CYC(4), .TO_CYC(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .cont_i(cont_i), .abort_i(abort_i),
    .eodac_i(eodac_i), .eoadc_i(eoadc_i), .pix_ready_i(pix_ready_i), .stdac_o(stdac_o),
    .dacch_o(dacch_o), .stadc_o(stadc_o), .row_o(row_o), .col_o(col_o),
    .pix_valid_o(pix_valid_o), .frame_done_o(frame_done_o), .busy_o(busy_o),
    .eos_o(eos_o), .err_o(err_o));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  function automatic int rc();
    return int'(row_o) * 16 + int'(col_o);
  endfunction

  function automatic bit cond(input int sel, input int r, input int c);
    case (sel)
      0: return eos_o;
      1: return frame_done_o;
      2: return pix_valid_o;
      3: return stdac_o;
      default: return stadc_o && rc() == r * 16 + c;
    endcase
  endfunction

  task automatic wait_for(input string nm, input int sel, input int r = 0, input int c = 0);
    bit hit = 0;
    for (int i = 0; i < 3000; i++) begin
      if (cond(sel, r, c)) begin
        hit = 1;
        break;
      end
      tick();
    end
    chk(nm, hit, 1);
  endtask

  task automatic push_frame(input int npix = 6, input bit fr = 1);
    q_dac.push_back(0);
    q_dac.push_back(1);
    for (int p = 0; p < npix; p++) q_adc.push_back((p / 3) * 16 + p % 3);
    if (fr) q_fr.push_back(1 * 16 + 2);
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // DAC/ADC models: answer each start pulse after a short fixed latency
  always @(negedge clk) begin
    eodac_i = dac_dly == 1;
    eoadc_i = adc_dly == 1 || man_adc;
    if (dac_dly > 0) dac_dly--;
    if (adc_dly > 0) adc_dly--;
    if (stdac_o && dac_en) dac_dly = 3;
    if (stadc_o && !(skip_en && rc() == 16)) adc_dly = 2;
  end

  always @(negedge clk) begin
    if (!rst_i) begin
      if (stdac_o) begin
        chk("dac_expected", q_dac.size() > 0, 1);
        if (q_dac.size() > 0) chk("dacch", dacch_o, q_dac.pop_front());
      end
      if (stadc_o) begin
        adc_seen++;
        chk("adc_expected", q_adc.size() > 0, 1);
        if (q_adc.size() > 0) chk("adc_rowcol", rc(), q_adc.pop_front());
      end
      if (frame_done_o) begin
        chk("frame_expected", q_fr.size() > 0, 1);
        if (q_fr.size() > 0) chk("frame_rowcol", rc(), q_fr.pop_front());
      end
      if (pix_valid_o && pv_prev) chk("rc_hold_valid", rc(), prev_rc);
    end
    pv_prev = pix_valid_o;
    prev_rc = rc();
  end

  initial begin
    int base;
    tick(3);
    chk("rst_eos", eos_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_strobes", {stdac_o, stadc_o, pix_valid_o, frame_done_o}, 0);
    chk("rst_counters", {dacch_o, row_o, col_o}, 0);
    chk("rst_err", err_o, 0);
    rst_i = 1'b0;
    tick(2);
    // single frame, with a start pulse mid-frame that must be ignored
    push_frame();
    pulse_start();
    chk("busy_after_start", busy_o, 1);
    wait_for("wait_pix02", 4, 0, 2);
    pulse_start();
    wait_for("wait_fd1", 1);
    wait_for("wait_idle1", 0);
    tick();
    chk("f1_adc_count", adc_seen, 6);
    chk("f1_queues_empty", q_dac.size() + q_adc.size() + q_fr.size(), 0);
    // backpressure on pixel (0,1)
    push_frame();
    pulse_start();
    wait_for("wait_pix01", 4, 0, 1);
    pix_ready_i = 1'b0;
    wait_for("wait_valid01", 2);
    repeat (10) begin
      chk("bp_valid", pix_valid_o, 1);
      chk("bp_rowcol", rc(), 1);
      tick();
    end
    pix_ready_i = 1'b1;
    tick();
    chk("bp_valid_drop", pix_valid_o, 0);
    chk("bp_rc_next", rc(), 1);
    tick();
    chk("bp_advance", rc(), 2);
    wait_for("wait_fd2", 1);
    wait_for("wait_idle2", 0);
    // continuous mode, two back-to-back frames
    tick();
    base = adc_seen;
    cont_i = 1'b1;
    push_frame();
    push_frame();
    pulse_start();
    wait_for("wait_fd3", 1);
    tick();
    chk("cont_restart_stdac", stdac_o, 1);
    chk("cont_restart_dacch", dacch_o, 0);
    cont_i = 1'b0;
    tick();
    wait_for("wait_fd4", 1);
    wait_for("wait_idle3", 0);
    tick();
    chk("cont_adc_count", adc_seen - base, 12);
    chk("cont_queues_empty", q_dac.size() + q_adc.size() + q_fr.size(), 0);
    // abort while waiting for the ADC at pixel (1,0)
    skip_en = 1;
    push_frame(4, 0);
    pulse_start();
    wait_for("wait_pix10", 4, 1, 0);
    tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_eos", eos_o, 1);
    chk("abort_busy", busy_o, 0);
    chk("abort_rowcol", rc(), 0);
    chk("abort_no_fd", frame_done_o, 0);
    man_adc = 1;
    tick();
    man_adc = 0;
    tick(3);
    chk("abort_late_eoadc", {eos_o, pix_valid_o, stadc_o}, 3'b100);
    skip_en = 0;
    // synchronous reset in PIX_OUT; a pulse between edges must not reset
    pix_ready_i = 1'b0;
    push_frame(1, 0);
    pulse_start();
    wait_for("wait_valid00", 2);
    rst_i = 1'b1;
    #2 rst_i = 1'b0;
    tick();
    chk("async_rst_ignored", {pix_valid_o, eos_o}, 2'b10);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("sync_rst_valid", pix_valid_o, 0);
    chk("sync_rst_eos", {eos_o, busy_o}, 2'b10);
    pix_ready_i = 1'b1;
    tick(2);
    chk("rst_stays_idle", eos_o, 1);
`ifdef FSM_MATRIX_TIMEOUT_EN
    dac_en = 0;
    q_dac.push_back(0);
    pulse_start();
    wait_for("wait_stdac_to", 3);
    tick(8);
    chk("to_not_yet", eos_o, 0);
    tick();
    chk("to_idle", eos_o, 1);
    chk("to_err", err_o, 1);
    dac_en = 1;
    tick(2);
    chk("to_err_sticky", err_o, 1);
    push_frame();
    pulse_start();
    chk("to_err_clear", err_o, 0);
    wait_for("wait_fd_to", 1);
    wait_for("wait_idle_to", 0);
`endif
    tick(2);
    chk("final_queues_empty", q_dac.size() + q_adc.size() + q_fr.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fsm_matrix_scan_param.md
Name: fsm_matrix_scan_param

Overview:
- Parametrised successor of the fixed 2x2 matrix-scan controller.
- Each frame: programs DAC_WRITES bias channels once, then raster-scans a ROWS x COLS bolometer matrix. Per pixel it selects row/col, waits a settle time, runs an ADC conversion and hands the pixel off through a valid/ready handshake.
- Owns the row/col/settle counters internally; they are no longer external count inputs.
- Sits between the top-level sequencer and the DAC/ADC SPI drivers and the pixel sink (LEDs or UART).

Parameters:
- ROWS, 4, matrix rows (>=1).
- COLS, 4, matrix columns (>=1).
- ROW_W, $clog2(ROWS) min 1, row index width.
- COL_W, $clog2(COLS) min 1, column index width.
- DAC_WRITES, 2, DAC channel writes per frame (>=1).
- DACCH_W, $clog2(DAC_WRITES) min 1, DAC channel index width.
- SETTLE_CYC, 16, cycles held after pixel select and after each DAC write before proceeding (>=1).
- TO_CYC, 4096, handshake timeout in cycles (used only with the optional feature).

Ports:
- clk_i, in, 1, system clock.
- rst_i, in, 1, synchronous active-high reset.
- start_i, in, 1, start a frame (level-sampled in IDLE).
- cont_i, in, 1, continuous mode: at end of frame, restart without start_i.
- abort_i, in, 1, abort the current frame.
- eodac_i, in, 1, DAC transfer done pulse.
- eoadc_i, in, 1, ADC conversion done pulse.
- pix_ready_i, in, 1, pixel sink ready.
- stdac_o, out, 1, one-cycle DAC start.
- dacch_o, out, DACCH_W, DAC channel being written.
- stadc_o, out, 1, one-cycle ADC start.
- row_o, out, ROW_W, selected row.
- col_o, out, COL_W, selected column.
- pix_valid_o, out, 1, pixel result valid for the sink.
- frame_done_o, out, 1, one-cycle pulse on the last pixel accepted.
- busy_o, out, 1, frame in progress.
- eos_o, out, 1, end of sequence/idle (1 in IDLE).
- err_o, out, 1, sticky timeout flag (tied to 0 without the optional feature).

Behaviour:
- All state, counters and outputs are registered. Only rst_i=1 at a clock edge resets. Reset values:
  - all outputs 0 except eos_o=1;
  - counters 0; state IDLE.
- States:
  - IDLE: eos_o=1, busy_o=0. If start_i, clear dacch/row/col and go to DAC_ST.
  - DAC_ST: stdac_o=1 for exactly one cycle, then DAC_WT.
  - DAC_WT: wait for eodac_i, then DAC_SET.
  - DAC_SET: run the settle counter for SETTLE_CYC cycles. Then, if dacch==DAC_WRITES-1, go to PIX_SEL; else dacch+1 and go to DAC_ST.
  - PIX_SEL: row_o/col_o are stable. Settle SETTLE_CYC cycles, then ADC_ST.
  - ADC_ST: stadc_o=1 for one cycle, then ADC_WT.
  - ADC_WT: wait for eoadc_i, then PIX_OUT.
  - PIX_OUT: pix_valid_o=1, held until pix_ready_i. Accepted on the cycle both are 1, then NEXT.
  - NEXT:
    - If col<COLS-1: col+1, go to PIX_SEL.
    - Else if row<ROWS-1: col=0, row+1, go to PIX_SEL.
    - Else: frame_done_o=1 for one cycle. If cont_i=1, clear dacch/row/col and go to DAC_ST (DAC re-programmed every frame); otherwise go to IDLE.
- busy_o=1 and eos_o=0 in every state except IDLE.
- row_o/col_o change only in NEXT or on frame start. They never change while pix_valid_o=1.
- Scan order is row-major: col is the inner index. Pixels per frame = ROWS*COLS. Both counters wrap to 0 at frame end.
- eodac_i/eoadc_i are ignored outside their wait states. A pulse coinciding with the start cycle is also ignored.
- abort_i has priority over every transition except reset. In any non-IDLE state, the next state is IDLE with counters cleared and no frame_done_o.
  - If abort_i arrives in PIX_OUT, pix_valid_o drops even without ready.
- start_i asserted while busy is ignored.
- ROWS=1 or COLS=1 are legal. ROWS=COLS=1 gives a single-pixel frame.

Optional Feature:
- Macro FSM_MATRIX_TIMEOUT_EN.
- Defined:
  - A TO_CYC cycle counter runs in DAC_WT and ADC_WT, cleared on state entry.
  - On expiry: set err_o (sticky until reset or next start_i accepted in IDLE) and go to IDLE with counters cleared.
- Undefined: no counter; wait states block indefinitely; err_o tied 0.

Test Plan:
- Case 1, ROWS=2, COLS=3, DAC_WRITES=2, SETTLE_CYC=4, ready always 1, start pulse:
  - 2 stdac pulses, dacch 0 then 1;
  - then 6 stadc pulses with (row,col) = (0,0)(0,1)(0,2)(1,0)(1,1)(1,2);
  - one frame_done_o;
  - return to eos_o=1.
- Pixel backpressure: hold pix_ready_i=0 for 10 cycles on pixel (0,1).
  - pix_valid_o stays 1 and row/col stay (0,1) for those 10 cycles.
  - Advance occurs the cycle after ready=1.
- Continuous mode, cont_i=1: after frame_done_o, the next cycle is DAC_ST with no start_i. Two frames complete, giving 12 stadc pulses.
- abort_i during ADC_WT at pixel (1,0):
  - IDLE next cycle, eos_o=1, row/col=0, no frame_done_o;
  - a later eoadc_i is ignored.
- Synchronous reset mid-PIX_OUT:
  - pix_valid_o=0, eos_o=1, state IDLE after the edge;
  - an asynchronous rst_i pulse between edges has no effect.
- With FSM_MATRIX_TIMEOUT_EN and TO_CYC=8, eodac_i withheld: err_o=1 and IDLE 8 cycles after DAC_WT entry; err_o clears on the next accepted start.
